key_conditioner: RTL and testbench

KEY_CONDITIONER -- requirements
Module: key_conditioner

---
 rtl/key_conditioner.sv | 161 ++++++++++++++++
 tb/tb_key_conditioner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Two-channel push-button conditioner: synchronise, debounce, and emit press/release pulses.
// Optional auto-repeat of key_press while a key stays held is enabled by defining KEY_AUTOREPEAT_EN.
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] KEY,
    output logic [1:0] key_level,
    output logic [1:0] key_press,
    output logic [1:0] key_release
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEY_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        logic           sync_meta;
        logic           sync_s;
        logic           pressed;
        state_t         state, state_nxt;
        logic [CNT_W-1:0] cnt, cnt_nxt;
        logic           press_nxt, release_nxt, level_nxt, rpt_fire;
        logic           level_q, press_q, release_q;

        // Synchroniser resets to "released" so a reset never fakes a press.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                sync_meta <= 1'b1;
                sync_s    <= 1'b1;
            end else begin
                // NOTE: non-blocking assignments make the two flops a true shift stage.
                sync_meta <= KEY[ch];
                sync_s    <= sync_meta;
            end
        end

        assign pressed = ~sync_s;

        always_comb begin
            // NOTE: every output gets a default first so no path leaves a latch behind.
            state_nxt   = state;
            cnt_nxt     = cnt;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            unique case (state)
                IDLE: begin
                    if (pressed) begin
                        state_nxt = PRESS_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (cnt >= CNT_LAST) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                        press_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!pressed) begin
                        state_nxt = RELEASE_WAIT;
                        cnt_nxt   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed) begin
                        state_nxt = HELD;
                        cnt_nxt   = '0;
                    end else if (cnt >= CNT_LAST) begin
                        state_nxt   = IDLE;
                        cnt_nxt     = '0;
                        release_nxt = 1'b1;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end
            endcase
            level_nxt = (state_nxt == HELD) || (state_nxt == RELEASE_WAIT);
        end

`ifdef KEY_AUTOREPEAT_EN
        logic [RPT_W-1:0] rpt_cnt, rpt_cnt_nxt;
        logic             rpt_phase, rpt_phase_nxt;

        // rpt_phase selects the first (long) delay or the steady repeat period.
        always_comb begin
            rpt_cnt_nxt   = '0;
            rpt_phase_nxt = 1'b0;
            rpt_fire      = 1'b0;
            if (state == HELD && state_nxt == HELD) begin
                if (rpt_cnt >= (rpt_phase ? PERIOD_LAST : DELAY_LAST)) begin
                    rpt_fire      = 1'b1;
                    rpt_phase_nxt = 1'b1;
                end else begin
                    rpt_cnt_nxt   = rpt_cnt + 1'b1;
                    rpt_phase_nxt = rpt_phase;
                end
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                rpt_cnt   <= '0;
                rpt_phase <= 1'b0;
            end else begin
                rpt_cnt   <= rpt_cnt_nxt;
                rpt_phase <= rpt_phase_nxt;
            end
        end
`else
        assign rpt_fire = 1'b0;
`endif

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state     <= IDLE;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_nxt;
                cnt       <= cnt_nxt;
                level_q   <= level_nxt;
                press_q   <= press_nxt | rpt_fire;
                release_q <= release_nxt;
            end
        end

        assign key_level[ch]   = level_q;
        assign key_press[ch]   = press_q;
        assign key_release[ch] = release_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Randomised self-checking bench for key_conditioner against a run-length debounce model.
// The reference tracks, per key, how many consecutive samples disagree with the accepted level.
module tb_key_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] KEY;
    logic [1:0] key_level, key_press, key_release;

    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .KEY        (KEY),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: raw-key delay line, accepted level, disagreement run, time held.
    int q1 [2];
    int q2 [2];
    int lvl[2];
    int run[2];
    int age[2];
    logic [1:0] exp_level, exp_press, exp_release;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            q1[c] = 1; q2[c] = 1; lvl[c] = 0; run[c] = 0; age[c] = 0;
        end
        exp_level = 2'b00; exp_press = 2'b00; exp_release = 2'b00;
    endtask

    // One rising edge: a level change is accepted once D+1 successive samples disagree with it.
    task automatic model_edge(input logic [1:0] k);
        for (int c = 0; c < 2; c++) begin
            int  pr;
            bit  was_held;
            was_held       = (lvl[c] == 1) && (run[c] == 0);
            exp_press[c]   = 1'b0;
            exp_release[c] = 1'b0;
            pr = (q2[c] == 0) ? 1 : 0;
            if (pr != lvl[c]) begin
                run[c]++;
                if (run[c] == D + 1) begin
                    lvl[c] = pr;
                    run[c] = 0;
                    if (pr == 1) exp_press[c] = 1'b1;
                    else         exp_release[c] = 1'b1;
                end
            end else begin
                run[c] = 0;
            end
            if (lvl[c] == 1 && run[c] == 0 && was_held) begin
                age[c]++;
`ifdef KEY_AUTOREPEAT_EN
                if (age[c] == RD || (age[c] > RD && (age[c] - RD) % RP == 0))
                    exp_press[c] = 1'b1;
`endif
            end else begin
                age[c] = 0;
            end
            q2[c] = q1[c];
            q1[c] = int'(k[c]);
            exp_level[c] = (lvl[c] == 1);
        end
    endtask

    task automatic cycle(input logic [1:0] k);
        KEY = k;
        @(posedge clk);
        model_edge(k);
        #1;
        check("level", key_level, exp_level);
        check("press", key_press, exp_press);
        check("release", key_release, exp_release);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_level", key_level, 2'b00);
        check("rst_press", key_press, 2'b00);
        check("rst_release", key_release, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Edge index (0 = first edge with k applied) of the first pulse on channel ch, -1 if none in 20.
    task automatic find_event(input logic [1:0] k, input int ch, input bit rel,
                              output int idx, output logic [1:0] vec);
        idx = -1;
        vec = 2'b00;
        for (int i = 0; i < 20 && idx < 0; i++) begin
            cycle(k);
            if ((rel ? key_release[ch] : key_press[ch]) === 1'b1) begin
                idx = i;
                vec = rel ? key_release : key_press;
            end
        end
    endtask

    initial begin
        int         idx;
        int         reps;
        logic [1:0] vec;
        logic [1:0] k;
        int         len;

        reset = 1'b0;
        KEY   = 2'b11;
        model_reset();
        #12;
        check("init_level", key_level, 2'b00);
        check("init_press", key_press, 2'b00);
        check("init_release", key_release, 2'b00);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (4) cycle(2'b11);

        find_event(2'b10, 0, 1'b0, idx, vec);
        check("clean_press_lat", idx, 6);
        check("clean_press_level", key_level, 2'b01);
        find_event(2'b11, 0, 1'b1, idx, vec);
        check("release_lat", idx, 6);
        check("release_level", key_level, 2'b00);

        repeat (3) cycle(2'b10);
        repeat (2) cycle(2'b11);
        find_event(2'b10, 0, 1'b0, idx, vec);
        check("bounce_lat", idx, 6);
        find_event(2'b11, 0, 1'b1, idx, vec);
        check("bounce_release_lat", idx, 6);

        find_event(2'b00, 0, 1'b0, idx, vec);
        check("dual_lat", idx, 6);
        check("dual_vec", vec, 2'b11);
        find_event(2'b11, 0, 1'b1, idx, vec);
        check("dual_rel_vec", vec, 2'b11);

        find_event(2'b01, 1, 1'b0, idx, vec);
        check("key1_lat", idx, 6);
        reps = 0;
        for (int i = 1; i <= 17; i++) begin
            cycle(2'b01);
            if (key_press[1] === 1'b1) reps++;
        end
`ifdef KEY_AUTOREPEAT_EN
        check("repeat_count", reps, 3);
`else
        check("repeat_count", reps, 0);
`endif
        find_event(2'b11, 1, 1'b1, idx, vec);
        check("key1_release_lat", idx, 6);
        reps = 0;
        for (int i = 0; i < 15; i++) begin
            cycle(2'b11);
            if (key_press[1] === 1'b1) reps++;
        end
        check("no_repeat_after_release", reps, 0);

        // Reset while a key is held, then mid-debounce with the key still down afterwards.
        find_event(2'b10, 0, 1'b0, idx, vec);
        do_reset();
        repeat (3) cycle(2'b10);
        do_reset();
        find_event(2'b10, 0, 1'b0, idx, vec);
        check("held_through_reset_lat", idx, 6);

        for (int it = 0; it < 300; it++) begin
            k   = 2'($urandom);
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(12, 30) : $urandom_range(1, 7);
            if ($urandom_range(0, 49) == 0) do_reset();
            for (int j = 0; j < len; j++) cycle(k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
